// File: rtl/hex_tick_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_tick_counter_if                                       |
// | Purpose  : Control and status bundle for hex_tick_counter.           |
// |            Enable  - lets the rate divider run                       |
// |            Up      - step direction, sampled only on step edges      |
// |            Load    - one-cycle synchronous load request              |
// |            LoadVal - four-digit load value, [3:0] least significant  |
// |            Count   - four digit nibbles, [3:0] least significant     |
// |            Tick    - registered pulse on every count step            |
// |            Wrap    - registered pulse on a full-range wrap           |
// | Modports : master drives the controls, slave is the counter itself.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface hex_tick_counter_if;
  logic        Enable;
  logic        Up;
  logic        Load;
  logic [15:0] LoadVal;
  logic [15:0] Count;
  logic        Tick;
  logic        Wrap;

  modport master (
    output Enable, Up, Load, LoadVal,
    input  Count, Tick, Wrap
  );

  modport slave (
    input  Enable, Up, Load, LoadVal,
    output Count, Tick, Wrap
  );
endinterface
`default_nettype wire

// File: rtl/hex_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_tick_counter                                          |
// | Purpose  : Four-digit up/down counter stepped once every DIV clocks. |
// |            BCD=0 counts each digit 0-F, BCD=1 counts each digit 0-9. |
// | Ports    : Clock  - single rising-edge clock                         |
// |            Resetn - synchronous active-low reset                     |
// |            bus    - hex_tick_counter_if.slave (controls + status)    |
// | Params   : DIV (2..2^26) clocks per step, BCD digit mode select      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hex_tick_counter #(
  parameter int DIV = 50000000,
  parameter int BCD = 0
) (
  input  logic                Clock,
  input  logic                Resetn,
  hex_tick_counter_if.slave   bus
);

  localparam int c_div_w = $clog2(DIV);
  localparam logic [c_div_w-1:0] c_reload = c_div_w'(DIV - 1);

  logic [c_div_w-1:0] r_div;
  logic [15:0]        r_count;
  logic               r_tick;
  logic               r_wrap;

  logic [15:0] w_next;
  logic [15:0] w_load_val;
  logic        w_wrap;
  logic        w_carry;
  logic [3:0]  w_dig;

  // Next count value, wrap detect and load clamp. Only consumed on step
  // or load edges, so Up changing between steps has no effect.
  always_comb begin
    w_next     = r_count;
    w_load_val = bus.LoadVal;
    w_wrap     = 1'b0;
    w_carry    = 1'b1;
    w_dig      = 4'd0;
    if (BCD != 0) begin
      // Ripple the carry/borrow through the digits; a digit only changes
      // while a carry is still pending from the digits below it.
      for (int i = 0; i < 4; i++) begin
        w_dig = r_count[4*i +: 4];
        if (w_carry) begin
          if (bus.Up) begin
            if (w_dig == 4'd9) begin
              w_dig = 4'd0;
            end else begin
              w_dig   = w_dig + 4'd1;
              w_carry = 1'b0;
            end
          end else begin
            if (w_dig == 4'd0) begin
              w_dig = 4'd9;
            end else begin
              w_dig   = w_dig - 4'd1;
              w_carry = 1'b0;
            end
          end
        end
        w_next[4*i +: 4] = w_dig;
        // Out-of-range load digits saturate so Count stays valid BCD.
        if (bus.LoadVal[4*i +: 4] > 4'd9) begin
          w_load_val[4*i +: 4] = 4'd9;
        end
      end
      w_wrap = bus.Up ? (r_count == 16'h9999) : (r_count == 16'h0000);
    end else begin
      w_next = bus.Up ? (r_count + 16'd1) : (r_count - 16'd1);
      w_wrap = bus.Up ? (r_count == 16'hFFFF) : (r_count == 16'h0000);
    end
  end

  // Reset beats Load, Load beats stepping and Enable.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_count <= 16'h0000;
      r_div   <= c_reload;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.Load) begin
      r_count <= w_load_val;
      r_div   <= c_reload;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.Enable) begin
      if (r_div == '0) begin
        r_div   <= c_reload;
        r_count <= w_next;
        r_tick  <= 1'b1;
        r_wrap  <= w_wrap;
      end else begin
        r_div  <= r_div - 1'b1;
        r_tick <= 1'b0;
        r_wrap <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign bus.Count = r_count;
  assign bus.Tick  = r_tick;
  assign bus.Wrap  = r_wrap;

endmodule
`default_nettype wire
